skip_cnt_ctrl: RTL

//  Sequencing controller for a programmable skip counter. The counter steps by step_lo while
//  cnt<=thresh and by step_hi above it, then wraps to 0. The controller owns configuration
//  (valid/ready handshake), start/pause/abort control and wrap accounting. It also raises done

---
 rtl/skip_cnt_pkg.sv | 7 +
 rtl/skip_cnt_core.sv | 39 +++
 rtl/skip_cnt_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/skip_cnt_pkg.sv
// skip_cnt_pkg: shared state encoding and power-on configuration defaults for the skip counter
package skip_cnt_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;
    localparam int DEF_THRESH  = 8;
    localparam int DEF_STEP_LO = 1;
    localparam int DEF_STEP_HI = 2;
endpackage

// File: rtl/skip_cnt_core.sv
// skip_cnt_core: count register with threshold-selected step and wrap detection
//   clk, rst          clock / async active-high reset
//   en                advance the count this cycle
//   clr               force the count to 0 (wins over en)
//   thresh            step-switch threshold
//   step_lo, step_hi  increments used at or below / above thresh
//   cnt               current count
//   wrap_now          advancing this cycle would wrap to 0
module skip_cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] thresh,
    input  logic [WIDTH-1:0] step_lo,
    input  logic [WIDTH-1:0] step_hi,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap_now
);
    localparam logic [WIDTH:0] MAX = {1'b0, {WIDTH{1'b1}}};
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_sum;
    assign w_step   = (r_cnt > thresh) ? step_hi : step_lo;
    // one extra bit so an overshoot past MAX is visible
    assign w_sum    = {1'b0, r_cnt} + {1'b0, w_step};
    assign wrap_now = (r_cnt == {WIDTH{1'b1}}) || (w_sum > MAX);
    assign cnt      = r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= wrap_now ? '0 : w_sum[WIDTH-1:0];
    end
endmodule

// File: rtl/skip_cnt_ctrl.sv
// skip_cnt_ctrl: FSM, config handshake, wrap accounting and pulses around skip_cnt_core
//   clk, rst                  clock / async active-high reset
//   cfg_valid, cfg_ready      config handshake (accepted only in IDLE)
//   cfg_thresh, cfg_step_lo,
//   cfg_step_hi, cfg_nwrap    offered configuration (nwrap 0 = free-run)
//   start, pause, abort       control; abort > pause > start
//   cnt, cnt_vld              count value, valid while running
//   wrap, wrap_cnt            wrap pulse, saturating wraps since start
//   busy, done                RUN/PAUSE indicator, end-of-job pulse
//   cfg_err                   last accepted offer had a zero step
module skip_cnt_ctrl
    import skip_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NWRAP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_thresh,
    input  logic [WIDTH-1:0]   cfg_step_lo,
    input  logic [WIDTH-1:0]   cfg_step_hi,
    input  logic [NWRAP_W-1:0] cfg_nwrap,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   cnt,
    output logic               cnt_vld,
    output logic               wrap,
    output logic [NWRAP_W-1:0] wrap_cnt,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    state_t               r_state, w_next;
    logic [WIDTH-1:0]     r_thresh, r_lo, r_hi;
    logic [NWRAP_W-1:0]   r_nwrap, r_wrap_cnt;
    logic                 r_wrap, r_cfg_err;
    logic                 w_cfg_acc, w_cfg_bad, w_start_go, w_en, w_clr, w_wrap_now, w_hit;
    logic [NWRAP_W:0]     w_wc_plus;
    assign w_cfg_acc  = cfg_valid && cfg_ready;
    assign w_cfg_bad  = (cfg_step_lo == '0) || (cfg_step_hi == '0);
    // a same-cycle config accept swallows the start
    assign w_start_go = (r_state == ST_IDLE) && start && !abort && !pause && !w_cfg_acc;
    assign w_en       = (r_state == ST_RUN) && !abort && !pause;
    assign w_clr      = abort || (r_state == ST_IDLE) || (r_state == ST_DONE);
    // compare in NWRAP_W+1 bits so a saturated counter never matches spuriously
    assign w_wc_plus  = {1'b0, r_wrap_cnt} + 1'b1;
    assign w_hit      = (r_nwrap != '0) && (w_wc_plus == {1'b0, r_nwrap});
    skip_cnt_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (w_en),
        .clr      (w_clr),
        .thresh   (r_thresh),
        .step_lo  (r_lo),
        .step_hi  (r_hi),
        .cnt      (cnt),
        .wrap_now (w_wrap_now)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_start_go ? ST_RUN : ST_IDLE;
            ST_RUN:   w_next = abort ? ST_IDLE : pause ? ST_PAUSE :
                               (w_wrap_now && w_hit) ? ST_DONE : ST_RUN;
            ST_PAUSE: w_next = abort ? ST_IDLE : pause ? ST_PAUSE : start ? ST_RUN : ST_PAUSE;
            default:  w_next = ST_IDLE;
        endcase
    end
    always_comb begin
        cfg_ready = (r_state == ST_IDLE);
        cnt_vld   = (r_state == ST_RUN);
        busy      = (r_state == ST_RUN) || (r_state == ST_PAUSE);
        done      = (r_state == ST_DONE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thresh  <= WIDTH'(DEF_THRESH);
            r_lo      <= WIDTH'(DEF_STEP_LO);
            r_hi      <= WIDTH'(DEF_STEP_HI);
            r_nwrap   <= '0;
            r_cfg_err <= 1'b0;
        end else if (w_cfg_acc) begin
            r_cfg_err <= w_cfg_bad;
            if (!w_cfg_bad) begin
                r_thresh <= cfg_thresh;
                r_lo     <= cfg_step_lo;
                r_hi     <= cfg_step_hi;
                r_nwrap  <= cfg_nwrap;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
        end else begin
            r_wrap <= w_en && w_wrap_now;
            if (w_start_go)
                r_wrap_cnt <= '0;
            else if (w_en && w_wrap_now && !(&r_wrap_cnt))
                r_wrap_cnt <= w_wc_plus[NWRAP_W-1:0];
        end
    end
    assign wrap     = r_wrap;
    assign wrap_cnt = r_wrap_cnt;
    assign cfg_err  = r_cfg_err;
endmodule
